// File: rtl/bcd_serial_calc.sv
// Serial BCD add/subtract calculator.
// One BCD digit is processed per clock, least significant digit first, and the
// finished result is presented as packed BCD plus seven-segment codes.
module bcd_serial_calc #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  error,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  carry_led,
  output logic                  busy,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a} code for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  state_t           state_r, state_s;
  logic [W-1:0]     a_sh_r, b_sh_r, acc_r, result_r;
  logic             op_r, c_r, err_r, carry_r, error_r, busy_r, done_r;
  logic [3:0]       idx_r;
  logic [7*DIGITS-1:0] seg_r;

  logic [3:0]       a_dig_s, b_dig_s, digit_s;
  logic [4:0]       sum_s;
  logic             c_next_s, dig_bad_s, err_final_s, borrow_s;
  logic [W-1:0]     acc_shift_s;
  logic [7*DIGITS-1:0] seg_s;

  // Next-state logic: IDLE -> CALC on start, CALC for DIGITS edges, one DONE cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = CALC;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; reset wins over every state.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // One digit step of the add/subtract chain, plus the shifted partial result
  // and the display codes it would produce if this were the last digit.
  always_comb begin
    a_dig_s     = a_sh_r[3:0];
    b_dig_s     = b_sh_r[3:0];
    dig_bad_s   = (a_dig_s > 4'd9) || (b_dig_s > 4'd9);
    err_final_s = err_r | dig_bad_s;
    sum_s       = 5'd0;
    borrow_s    = 1'b0;
    digit_s     = 4'd0;
    c_next_s    = 1'b0;
    if (!op_r) begin
      sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {4'd0, c_r};
      if (sum_s > 5'd9) begin
        digit_s  = 4'(sum_s - 5'd10);
        c_next_s = 1'b1;
      end else begin
        digit_s  = sum_s[3:0];
        c_next_s = 1'b0;
      end
    end else begin
      borrow_s = ({1'b0, a_dig_s} < ({1'b0, b_dig_s} + {4'd0, c_r}));
      if (borrow_s) begin
        digit_s  = 4'({1'b0, a_dig_s} + 5'd10 - {1'b0, b_dig_s} - {4'd0, c_r});
        c_next_s = 1'b1;
      end else begin
        digit_s  = 4'({1'b0, a_dig_s} - {1'b0, b_dig_s} - {4'd0, c_r});
        c_next_s = 1'b0;
      end
    end
    acc_shift_s = acc_r >> 4'd4;
    acc_shift_s[W-1 -: 4] = digit_s;
    seg_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (err_final_s) seg_s[7*i +: 7] = 7'b1111001;
      else             seg_s[7*i +: 7] = seg7(acc_shift_s[4*i +: 4]);
    end
  end

  // Datapath: latch operands on start, shift one digit per CALC edge,
  // and commit result/carry/error/seg only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      acc_r    <= '0;
      op_r     <= 1'b0;
      c_r      <= 1'b0;
      err_r    <= 1'b0;
      idx_r    <= 4'd0;
      result_r <= '0;
      carry_r  <= 1'b0;
      error_r  <= 1'b0;
      seg_r    <= {DIGITS{7'b0111111}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r <= a;
            b_sh_r <= b;
            op_r   <= op;
            idx_r  <= 4'd0;
            c_r    <= 1'b0;
            err_r  <= 1'b0;
            acc_r  <= '0;
          end
        end
        CALC: begin
          a_sh_r <= a_sh_r >> 4'd4;
          b_sh_r <= b_sh_r >> 4'd4;
          acc_r  <= acc_shift_s;
          c_r    <= c_next_s;
          err_r  <= err_final_s;
          idx_r  <= idx_r + 4'd1;
          if (idx_r == LAST_IDX) begin
            result_r <= err_final_s ? '0 : acc_shift_s;
            carry_r  <= err_final_s ? 1'b0 : c_next_s;
            error_r  <= err_final_s;
            seg_r    <= seg_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_r;
  assign carry     = carry_r;
  assign carry_led = carry_r;
  assign error     = error_r;
  assign seg       = seg_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_bcd_serial_calc.sv
// Self-checking bench for bcd_serial_calc (DIGITS=4), using an integer-arithmetic
// reference model of decimal add/subtract with 10^DIGITS wrap.
module tb_bcd_serial_calc;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst, start, op;
  logic [W-1:0] a, b, result;
  logic carry, error, carry_led, busy, done;
  logic [7*DIGITS-1:0] seg;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  bcd_serial_calc #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .carry(carry), .error(error), .seg(seg),
    .carry_led(carry_led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Reference: whole-number decimal arithmetic modulo 10^DIGITS.
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic e);
    int p, ix, iy;
    p = 10 ** DIGITS;
    e = has_bad(x) | has_bad(y);
    ix = to_int(x);
    iy = to_int(y);
    if (e) begin
      r = '0; c = 1'b0;
    end else if (!o) begin
      r = to_bcd((ix + iy) % p); c = ((ix + iy) >= p);
    end else if (ix >= iy) begin
      r = to_bcd(ix - iy); c = 1'b0;
    end else begin
      r = to_bcd(p + ix - iy); c = 1'b1;
    end
  endtask

  function automatic logic [7*DIGITS-1:0] seg_exp(input logic [W-1:0] r, input logic e);
    logic [7*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++) s[7*i +: 7] = e ? 7'b1111001 : seg_tab[r[4*i +: 4]];
    return s;
  endfunction

  // Launch one operation and return at the negedge of the DONE cycle
  // (lat = edges after the start edge; 20 means no done seen).
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({result, carry, carry_led, error, busy, done} !== {16'h0000, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_outputs got res=%h c=%b cl=%b e=%b busy=%b done=%b want all 0",
               result, carry, carry_led, error, busy, done);
    end
    n_checks++;
    if (seg !== {DIGITS{7'b0111111}}) begin
      n_fail++; $display("FAIL reset_seg got %b want %b", seg, {DIGITS{7'b0111111}});
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic          vo [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0]  va [4]  = '{16'h1234, 16'h0504, 16'h5347, 16'h2148};
    logic [W-1:0]  vb [4]  = '{16'h4321, 16'h9826, 16'h2148, 16'h5347};
    logic [W-1:0]  er;
    logic          ec, ee;
    int lat;
    for (int k = 0; k < 5; k++) begin
      logic o; logic [W-1:0] x, y;
      if (k < 4) begin o = vo[k]; x = va[k]; y = vb[k]; end
      else begin o = 1'b0; x = 16'h12A4; y = 16'h0000; end
      model(o, x, y, er, ec, ee);
      do_op(o, x, y, lat);
      n_checks++;
      if (lat !== DIGITS) begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", k, lat, DIGITS); end
      n_checks++;
      if ({result, carry, error} !== {er, ec, ee}) begin
        n_fail++;
        $display("FAIL vec%0d_result got res=%h c=%b e=%b want res=%h c=%b e=%b", k, result, carry, error, er, ec, ee);
      end
      n_checks++;
      if ({seg, carry_led, busy} !== {seg_exp(er, ee), ec, 1'b1}) begin
        n_fail++;
        $display("FAIL vec%0d_display got seg=%b cl=%b busy=%b want seg=%b cl=%b busy=1", k, seg, carry_led, busy, seg_exp(er, ee), ec);
      end
      @(negedge clk);
      n_checks++;
      if ({done, busy, result} !== {2'b00, er}) begin
        n_fail++; $display("FAIL vec%0d_after_done got done=%b busy=%b res=%h want 0 0 %h", k, done, busy, result, er);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, er;
    logic o, ec, ee;
    int lat, pos;
    for (int k = 0; k < 30; k++) begin
      o = 1'($urandom_range(0, 1));
      x = to_bcd(int'($urandom_range(0, 9999)));
      y = to_bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 7) == 0) begin
        pos = int'($urandom_range(0, DIGITS - 1));
        x[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      model(o, x, y, er, ec, ee);
      do_op(o, x, y, lat);
      n_checks++;
      if ({lat == DIGITS, result, carry, carry_led, error, seg} !== {1'b1, er, ec, ec, ee, seg_exp(er, ee)}) begin
        n_fail++;
        $display("FAIL rand%0d op=%b a=%h b=%h got lat=%0d res=%h c=%b cl=%b e=%b want lat=%0d res=%h c=%b e=%b",
                 k, o, x, y, lat, result, carry, carry_led, error, DIGITS, er, ec, ee);
      end
    end
  endtask

  task automatic test_abort();
    int lat, pulses;
    do_op(1'b0, 16'h1234, 16'h4321, lat);
    @(negedge clk);
    op = 1'b0; a = 16'h0504; b = 16'h9826; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, result, carry} !== {2'b00, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL abort_reset got busy=%b done=%b res=%h c=%b want 0 0 0000 0", busy, done, result, carry);
    end
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
    do_op(1'b1, 16'h2148, 16'h5347, lat);
    n_checks++;
    if ({lat == DIGITS, result, carry} !== {1'b1, 16'h6801, 1'b1}) begin
      n_fail++; $display("FAIL abort_restart got lat=%0d res=%h c=%b want lat=%0d res=6801 c=1", lat, result, carry, DIGITS);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] er, cap;
    logic ec, ee, capc;
    int pulses, lat;
    model(1'b1, 16'h5347, 16'h2148, er, ec, ee);
    @(negedge clk);
    op = 1'b1; a = 16'h5347; b = 16'h2148; start = 1'b1;
    @(negedge clk);
    op = 1'b0; a = 16'h9999; b = 16'h0001;
    pulses = 0; lat = 0; cap = '0; capc = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) start = 1'b0;
      if (done === 1'b1) begin pulses++; lat = k; cap = result; capc = carry; end
      a = to_bcd(int'($urandom_range(0, 9999)));
      b = to_bcd(int'($urandom_range(0, 9999)));
    end
    n_checks++;
    if (pulses != 1 || lat != DIGITS) begin
      n_fail++; $display("FAIL ignore_start_pulses got %0d pulses at %0d want 1 at %0d", pulses, lat, DIGITS);
    end
    n_checks++;
    if ({cap, capc} !== {er, ec}) begin
      n_fail++; $display("FAIL ignore_start_result got res=%h c=%b want res=%h c=%b", cap, capc, er, ec);
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    do_op(1'b0, 16'h1234, 16'h4321, lat);
    op = 1'b1; a = 16'h5347; b = 16'h2148; start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({n == DIGITS + 2, result, carry} !== {1'b1, 16'h3199, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second got n=%0d res=%h c=%b want n=%0d res=3199 c=0", n, result, carry, DIGITS + 2);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
